instr_delay_line: RTL and testbench
===================================

// Module: instr_delay_line
// PURPOSE
// - Parametrised instruction delay line feeding the decode stage; generalises the fixed two-register
//   Instr->Ins->Input chain and its 2:1 select into DEPTH registered stages with per-stage valid bits.
// - Sits between IFSTAGE and DECSTAGE. A runtime tap select picks the live fetch word or any delayed
//   stage. Adds hold (stall), flush with NOP injection, and occupancy/state tracking.
// PARAMETERS
// - DATA_W  32            instruction word width
// - DEPTH   2             number of delay stages (>=1); DEPTH=2 reproduces the legacy chain
// - TAP_W   $clog2(DEPTH+1)  width of Tap_sel
// - NOP     32'h0000_0000 word loaded on reset/flush (low DATA_W bits used)
// PORTS
// - clock       in   1       rising-edge clock
// - Reset       in   1       asynchronous, active-low reset
// - Instr_in    in   DATA_W  fetched instruction from IFSTAGE
// - Instr_valid in   1       Instr_in is a real instruction this cycle
// - Hold        in   1       stall: freeze every stage, valid bit and counter
// - Flush       in   1       discard all stages (load NOP, clear valid)
// - Tap_sel     in   TAP_W   0 = bypass Instr_in; k (1..DEPTH) = output of stage k
// - In          out  DATA_W  selected instruction to DECSTAGE
// - In_valid    out  1       selected word is valid
// - Fill_cnt    out  TAP_W   number of stages currently holding valid words
// - Full        out  1       all DEPTH stages valid
// - Empty       out  1       no stage valid
// BEHAVIOUR
// - Reset (Reset==0, async): all stages=NOP, valid=0, Fill_cnt=0, state=S_EMPTY, Empty=1, Full=0.
//   Registered outputs take reset values immediately, not at the next edge.
// - Shift (posedge, Flush=0, Hold=0): stage[1]<=Instr_in, v[1]<=Instr_valid; stage[k]<=stage[k-1],
//   v[k]<=v[k-1] for k=2..DEPTH. The stage[DEPTH] word is dropped.
// - Hold=1, Flush=0: no register changes. Instr_in is not sampled, so upstream must re-present it.
// - Flush=1: all stages<=NOP, v<=0 at the edge. Flush beats Hold. Instr_in that cycle is discarded.
// - Latency: tap k delivers Instr_in exactly k un-held edges later. Tap 0 is purely combinational.
// - Output mux (combinational):
//   - Tap_sel==0: In=Instr_in, In_valid=Instr_valid.
//   - 1<=Tap_sel<=DEPTH: In=stage[Tap_sel], In_valid=v[Tap_sel].
//   - Tap_sel>DEPTH: In=NOP, In_valid=0.
// - Fill_cnt: registered popcount of the next v vector. It always equals popcount(v) after each edge,
//   never exceeds DEPTH, and cannot wrap.
// - FSM (registered, next state from the next v vector):
//   - S_EMPTY: Fill_cnt==0.
//   - S_PARTIAL: 0<Fill_cnt<DEPTH.
//   - S_FULL: Fill_cnt==DEPTH.
//   - Any state -> S_EMPTY on Flush. With DEPTH=1, S_PARTIAL is unreachable.
//   - Empty=(state==S_EMPTY) and Full=(state==S_FULL), both from flops.
// - Tap_sel may change every cycle; a change affects only the mux, never register state.
// - Reset asserted mid-stream: contents are lost, and after release the line refills from empty.
// STRUCTURE
// - Package instr_dl_pkg holds:
//   - localparam NOP_WORD
//   - state typedef/encoding S_EMPTY=2'd0, S_PARTIAL=2'd1, S_FULL=2'd2
//   - function popcount
// - Sub-module dl_stage: one DATA_W word + valid flop with async active-low reset, load-enable
//   (=~Hold) and synchronous clear (=Flush). Instantiate it DEPTH times in a generate loop.
// - Top level: generate chain, output mux, popcount/FSM block.
// TESTING
// - Reset: drive Reset=0 with Instr_in=32'h2001_0005 and Tap_sel=2.
//   -> In=0, In_valid=0, Fill_cnt=0, Empty=1, with no clock edge needed.
// - Legacy equivalence (DEPTH=2): feed words A,B,C with valid on consecutive edges, Tap_sel=2.
//   -> In shows A two edges after A is presented, then B, then C.
//   -> Tap_sel=0 shows each word in the same cycle.
// - Fill/full: 3 valid words into DEPTH=3.
//   -> Fill_cnt goes 1,2,3; state EMPTY->PARTIAL->PARTIAL->FULL; Full=1.
//   -> One further invalid word gives Fill_cnt=2 and Full=0.
// - Hold: Hold=1 for 3 cycles with the line full (DEPTH=3, Tap_sel=3) while Instr_in changes.
//   -> In and Fill_cnt stay constant.
//   -> After release, the next word enters stage 1 and the old stage 3 word is dropped.
// - Flush vs Hold: Flush=1 and Hold=1 on the same edge with Full=1.
//   -> All valid=0, In=NOP for Tap_sel 1..DEPTH, Fill_cnt=0, Empty=1.
// - Out-of-range tap: DEPTH=2, TAP_W=2, Tap_sel=3, line full.
//   -> In=NOP, In_valid=0, and no register changes.

Source files
------------

// File: rtl/instr_dl_pkg.sv
// Shared definitions for the instruction delay line: the default NOP word,
// the occupancy state encoding and the popcount helper used for Fill_cnt.
package instr_dl_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // Upper bound on DEPTH that popcount can count.
  localparam int          MAX_DEPTH = 64;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } dl_state_e;

  function automatic logic [6:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/dl_stage.sv
// One delay-line stage: an instruction word plus its valid bit.
//   clock    rising-edge clock
//   Reset    asynchronous active-low reset (word <= RST_WORD, valid <= 0)
//   en       load enable; stage keeps its contents while low
//   clr      synchronous clear to RST_WORD / invalid; wins over en
//   d        incoming word
//   d_valid  incoming valid
//   q        stored word
//   q_valid  stored valid
module dl_stage #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RST_WORD = '0
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      q       <= RST_WORD;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= RST_WORD;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/instr_delay_line.sv
// Instruction delay line between fetch and decode. DEPTH registered stages
// with per-stage valid bits; a runtime tap picks the live fetch word (tap 0)
// or the output of stage k. Supports stall (Hold), flush with NOP injection,
// and tracks occupancy.
//   clock        rising-edge clock
//   Reset        asynchronous active-low reset
//   Instr_in     fetched instruction
//   Instr_valid  Instr_in carries a real instruction
//   Hold         freeze every stage, valid bit and the occupancy state
//   Flush        load NOP into every stage and clear all valids (beats Hold)
//   Tap_sel      0 = bypass, 1..DEPTH = stage k, above DEPTH = NOP/invalid
//   In           selected instruction to decode
//   In_valid     selected word is valid
//   Fill_cnt     number of valid stages
//   Full         every stage valid
//   Empty        no stage valid
module instr_delay_line
  import instr_dl_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 2,
  parameter int          TAP_W  = $clog2(DEPTH + 1),
  parameter logic [31:0] NOP    = NOP_WORD
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Instr_in,
  input  logic              Instr_valid,
  input  logic              Hold,
  input  logic              Flush,
  input  logic [TAP_W-1:0]  Tap_sel,
  output logic [DATA_W-1:0] In,
  output logic              In_valid,
  output logic [TAP_W-1:0]  Fill_cnt,
  output logic              Full,
  output logic              Empty
);

  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP);
  localparam int                NTAP    = 1 << TAP_W;
  localparam logic [TAP_W-1:0]  MAX_TAP = TAP_W'(DEPTH);

  // Entry 0 is the live fetch word, 1..DEPTH are stage outputs, and the
  // remaining entries pad the tap space with NOP/invalid so that an
  // out-of-range Tap_sel needs no separate compare.
  logic [NTAP-1:0][DATA_W-1:0] data_chain;
  logic [NTAP-1:0]             vld_chain;

  assign data_chain[0] = Instr_in;
  assign vld_chain[0]  = Instr_valid;

  // Stage boundary: stage k registers entry k-1 of the chain.
  for (genvar k = 1; k < NTAP; k++) begin : g_tap
    if (k <= DEPTH) begin : g_stage
      dl_stage #(
        .DATA_W   (DATA_W),
        .RST_WORD (NOP_W)
      ) u_stage (
        .clock   (clock),
        .Reset   (Reset),
        .en      (~Hold),
        .clr     (Flush),
        .d       (data_chain[k-1]),
        .d_valid (vld_chain[k-1]),
        .q       (data_chain[k]),
        .q_valid (vld_chain[k])
      );
    end else begin : g_pad
      assign data_chain[k] = NOP_W;
      assign vld_chain[k]  = 1'b0;
    end
  end

  assign In       = data_chain[Tap_sel];
  assign In_valid = vld_chain[Tap_sel];

  // Valid vector the stages will hold after this edge; occupancy is
  // derived from it so Fill_cnt/state line up with the stage flops.
  logic [DEPTH-1:0]     v_next;
  logic [MAX_DEPTH-1:0] v_ext;
  logic [TAP_W-1:0]     fill_d, fill_q;
  dl_state_e            state_d, state_q;

  always_comb begin
    if (Flush) begin
      v_next = '0;
    end else if (Hold) begin
      v_next = vld_chain[DEPTH:1];
    end else begin
      v_next = vld_chain[DEPTH-1:0];
    end
  end

  always_comb begin
    v_ext              = '0;
    v_ext[DEPTH-1:0]   = v_next;
  end

  always_comb begin
    fill_d  = TAP_W'(popcount(v_ext));
    state_d = S_PARTIAL;
    if (fill_d == '0) begin
      state_d = S_EMPTY;
    end else if (fill_d == MAX_TAP) begin
      state_d = S_FULL;
    end
  end

  // Occupancy register boundary.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_EMPTY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  assign Fill_cnt = fill_q;
  assign Empty    = (state_q == S_EMPTY);
  assign Full     = (state_q == S_FULL);

endmodule

// File: tb/tb_instr_delay_line.sv
module tb_instr_delay_line;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        Reset;
  logic [31:0] Instr_in;
  logic        Instr_valid, Hold, Flush;
  logic [1:0]  tap2, tap3;

  logic [31:0] in2, in3;
  logic        v2, v3, full2, full3, empty2, empty3;
  logic [1:0]  cnt2, cnt3;

  instr_delay_line #(.DATA_W(32), .DEPTH(2)) u_d2 (
    .clock(clock), .Reset(Reset), .Instr_in(Instr_in), .Instr_valid(Instr_valid),
    .Hold(Hold), .Flush(Flush), .Tap_sel(tap2), .In(in2), .In_valid(v2),
    .Fill_cnt(cnt2), .Full(full2), .Empty(empty2)
  );

  instr_delay_line #(.DATA_W(32), .DEPTH(3)) u_d3 (
    .clock(clock), .Reset(Reset), .Instr_in(Instr_in), .Instr_valid(Instr_valid),
    .Hold(Hold), .Flush(Flush), .Tap_sel(tap3), .In(in3), .In_valid(v3),
    .Fill_cnt(cnt3), .Full(full3), .Empty(empty3)
  );

  int n_cmp  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        vin;
    logic [31:0] w;
    logic [1:0]  t2, t3;
    logic [31:0] e2; logic ev2; logic [1:0] c2; logic f2;
    logic [31:0] e3; logic ev3; logic [1:0] c3; logic f3; logic m3;
  } vec_t;

  localparam logic [31:0] A = 32'hA000_0001, B = 32'hB000_0002, C = 32'hC000_0003,
                          D = 32'hD000_0004, E = 32'hE000_0005;

  vec_t        tbl [7];
  logic [31:0] xw  [4];

  initial begin
    // Expected values: outputs before the vector's clock edge.
    tbl[0] = '{1'b1, A, 2'd2, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, A, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, B, 2'd2, 2'd1, 32'h0, 1'b0, 2'd1, 1'b0, A, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, C, 2'd2, 2'd2, A,     1'b1, 2'd2, 1'b1, A, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, D, 2'd2, 2'd3, B,     1'b1, 2'd2, 1'b1, A, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, E, 2'd0, 2'd3, E,     1'b0, 2'd1, 1'b0, B, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, A, 2'd1, 2'd3, E,     1'b0, 2'd0, 1'b0, C, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, B, 2'd1, 2'd1, A,     1'b1, 2'd1, 1'b0, A, 1'b1, 2'd1, 1'b0, 1'b0};
    xw[0] = 32'h1111_0001; xw[1] = 32'h2222_0002; xw[2] = 32'h3333_0003; xw[3] = 32'h4444_0004;

    // Reset with no clock edge
    Reset = 1'b0; Instr_in = 32'h2001_0005; Instr_valid = 1'b0;
    Hold = 1'b0; Flush = 1'b0; tap2 = 2'd2; tap3 = 2'd2;
    #2;
    chk("rst_in",    in2, 32'h0);
    chk("rst_vld",   32'(v2), 32'h0);
    chk("rst_cnt",   32'(cnt2), 32'h0);
    chk("rst_empty", 32'(empty2), 32'h1);
    chk("rst_full",  32'(full2), 32'h0);
    tick();
    Reset = 1'b1;

    // Table: legacy equivalence, fill/full, tap changes
    for (int i = 0; i < 7; i++) begin
      Instr_in = tbl[i].w; Instr_valid = tbl[i].vin; tap2 = tbl[i].t2; tap3 = tbl[i].t3;
      #1;
      chk($sformatf("v%0d_in2", i),    in2, tbl[i].e2);
      chk($sformatf("v%0d_vld2", i),   32'(v2), 32'(tbl[i].ev2));
      chk($sformatf("v%0d_cnt2", i),   32'(cnt2), 32'(tbl[i].c2));
      chk($sformatf("v%0d_full2", i),  32'(full2), 32'(tbl[i].f2));
      chk($sformatf("v%0d_in3", i),    in3, tbl[i].e3);
      chk($sformatf("v%0d_vld3", i),   32'(v3), 32'(tbl[i].ev3));
      chk($sformatf("v%0d_cnt3", i),   32'(cnt3), 32'(tbl[i].c3));
      chk($sformatf("v%0d_full3", i),  32'(full3), 32'(tbl[i].f3));
      chk($sformatf("v%0d_empty3", i), 32'(empty3), 32'(tbl[i].m3));
      tick();
    end

    // Mid-stream asynchronous reset (line holds valid words here)
    Instr_in = 32'h2001_0005; tap2 = 2'd2; tap3 = 2'd2;
    Reset = 1'b0;
    #1;
    chk("mrst_in2",    in2, 32'h0);
    chk("mrst_vld2",   32'(v2), 32'h0);
    chk("mrst_cnt2",   32'(cnt2), 32'h0);
    chk("mrst_empty2", 32'(empty2), 32'h1);
    chk("mrst_cnt3",   32'(cnt3), 32'h0);
    #1;
    Reset = 1'b1;

    // Refill DEPTH=3 from empty: counts 1,2,3 and PARTIAL,PARTIAL,FULL
    Instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Instr_in = xw[k];
      tick();
      chk($sformatf("fill%0d_cnt3", k),   32'(cnt3), 32'(k + 1));
      chk($sformatf("fill%0d_empty3", k), 32'(empty3), 32'h0);
      chk($sformatf("fill%0d_full3", k),  32'(full3), (k == 2) ? 32'h1 : 32'h0);
    end

    // Hold for 3 edges with a full line while Instr_in changes
    tap3 = 2'd3; Hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      Instr_in = 32'hDEAD_0000 + 32'(j);
      #1;
      chk($sformatf("hold%0d_in3", j),  in3, xw[0]);
      chk($sformatf("hold%0d_cnt3", j), 32'(cnt3), 32'h3);
      tick();
    end
    chk("hold_end_in3", in3, xw[0]);
    Hold = 1'b0; Instr_in = xw[3];
    tick();
    chk("rel_tap3_in3", in3, xw[1]);
    chk("rel_tap3_vld", 32'(v3), 32'h1);
    tap3 = 2'd1;
    #1;
    chk("rel_tap1_in3", in3, xw[3]);
    chk("rel_cnt3",     32'(cnt3), 32'h3);

    // Flush and Hold together on a full line
    chk("pre_flush_full3", 32'(full3), 32'h1);
    chk("pre_flush_full2", 32'(full2), 32'h1);
    Flush = 1'b1; Hold = 1'b1; Instr_in = 32'h5555_0005; Instr_valid = 1'b1;
    tick();
    Flush = 1'b0; Instr_valid = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tap3 = 2'(t);
      #1;
      chk($sformatf("flush_tap%0d_in3", t),  in3, 32'h0);
      chk($sformatf("flush_tap%0d_vld3", t), 32'(v3), 32'h0);
    end
    chk("flush_cnt3",   32'(cnt3), 32'h0);
    chk("flush_empty3", 32'(empty3), 32'h1);
    chk("flush_full3",  32'(full3), 32'h0);
    chk("flush_cnt2",   32'(cnt2), 32'h0);
    chk("flush_empty2", 32'(empty2), 32'h1);

    // Out-of-range tap on DEPTH=2, line full, held across an edge
    Hold = 1'b0; Instr_valid = 1'b1; Instr_in = 32'h6666_0001;
    tick();
    Instr_in = 32'h7777_0002;
    tick();
    Hold = 1'b1; Instr_valid = 1'b0; tap2 = 2'd3;
    #1;
    chk("oor_in2",  in2, 32'h0);
    chk("oor_vld2", 32'(v2), 32'h0);
    tick();
    chk("oor_hold_in2", in2, 32'h0);
    chk("oor_cnt2",     32'(cnt2), 32'h2);
    chk("oor_full2",    32'(full2), 32'h1);
    tap2 = 2'd2;
    #1;
    chk("oor_tap2_in2", in2, 32'h6666_0001);
    tap2 = 2'd1;
    #1;
    chk("oor_tap1_in2", in2, 32'h7777_0002);
    chk("oor_tap1_vld", 32'(v2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
